program_counter: RTL and testbench
==================================

PROGRAM_COUNTER -- requirements
Module: program_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the counter and data width in bits.
REQ-002 The block SHALL have parameter RESET_VAL, default 0, giving the value loaded by rst_n and by clr.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port in, input, WIDTH bits: jump target, written into the counter when load is high.
REQ-006 Port load, input, 1 bit: when high, the counter takes in on the next edge.
REQ-007 Port inc, input, 1 bit: when high, the counter increments by 1 on the next edge.
REQ-008 Port clr, input, 1 bit: synchronous clear to RESET_VAL; this is the Hack-level CPU reset.
REQ-009 Port out, output, WIDTH bits: current counter value, driven directly from the state register.
REQ-010 Port wrap, output, 1 bit: registered one-cycle pulse that flags an increment from all-ones to zero.

Function
REQ-011 The block SHALL evaluate its controls on each rising clk edge in strict priority clr > load > inc > hold.
REQ-012 If clr=1 the block SHALL set out to RESET_VAL, whatever load, inc and in are.
REQ-013 Else if load=1 the block SHALL set out to in and ignore inc.
REQ-014 Else if inc=1 the block SHALL set out to (out+1) mod 2^WIDTH.
REQ-015 Otherwise out SHALL hold its previous value.
REQ-016 Latency SHALL be exactly one cycle: any control change is visible on out after the next rising edge, and out SHALL have no combinational path from inputs.
REQ-017 On the edge where inc takes effect with out equal to all-ones, the block SHALL wrap out to 0 and set wrap=1 for exactly one cycle.
REQ-018 wrap SHALL be 0 on every other edge, including load of all-ones, load of 0, clr, and hold.
REQ-019 The incrementer SHALL be WIDTH bits wide with the carry-out used only to generate wrap; no saturation.
REQ-020 The block SHALL accept loading the value it already holds; out is unchanged and wrap=0.

Reset
REQ-021 When rst_n is low, out SHALL be RESET_VAL and wrap SHALL be 0, immediately and independent of clk.
REQ-022 While rst_n is low, the block SHALL ignore load, inc and clr.
REQ-023 On the first rising edge after rst_n deasserts, the block SHALL apply normal priority (REQ-011) with no extra dead cycle.
REQ-024 If rst_n asserts mid-count, the count SHALL be lost and out SHALL return to RESET_VAL.

Structure
REQ-025 WIDTH default (16) and RESET_VAL default (0) SHALL come from the team's shared Hack constants file, which all word-width blocks use.
REQ-026 One sub-module, inc16 (a combinational WIDTH-bit +1 with carry-out), SHALL be instantiated for the increment path.
REQ-027 The next-state selection SHALL be a single priority mux feeding one WIDTH-bit state flop and one wrap flop, both with asynchronous active-low reset.

Verification
REQ-028 Reset test: rst_n=0 asserted mid-cycle with out=0x0042 -> out=0x0000 and wrap=0 before the next edge; load=1, in=0x1111 held during reset -> out stays 0x0000.
REQ-029 Count test: rst_n=1, inc=1 for 3 edges -> out reads 0x0001, 0x0002, 0x0003 in turn; then inc=0 for 2 edges -> out stays 0x0003.
REQ-030 Load-over-inc test: load=1, inc=1, in=0xABCD -> out=0xABCD after 1 edge; then load=0, inc=1 -> out=0xABCE.
REQ-031 Wrap test: load in=0xFFFF, then inc=1 -> out=0x0000 and wrap=1 for that one cycle; next inc -> out=0x0001 and wrap=0.
REQ-032 Clear-priority test: clr=1, load=1, inc=1, in=0x5678 while out=0x1234 -> out=0x0000 and wrap=0 after 1 edge.
REQ-033 Hold test: load=0, inc=0, clr=0 and in toggled among 0x5678, 0x9999, 0x0000 over 4 edges -> out unchanged from its prior value (0x1234).

Source files
------------

// File: rtl/program_counter_pkg.sv
// Shared Hack word-width constants used by all word-wide blocks.
package program_counter_pkg;

    localparam int unsigned HACK_WIDTH = 16;
    localparam logic [HACK_WIDTH-1:0] HACK_RESET_VAL = '0;

endpackage

// File: rtl/inc16.sv
// Combinational WIDTH-bit +1 with carry-out.
module inc16 #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] sum,
    output logic             carry
);

    assign {carry, sum} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};

endmodule

// File: rtl/program_counter.sv
// Hack program counter: priority clr > load > inc > hold, registered out and wrap pulse.
module program_counter
    import program_counter_pkg::*;
#(
    parameter int unsigned       WIDTH     = HACK_WIDTH,
    parameter logic [WIDTH-1:0]  RESET_VAL = WIDTH'(HACK_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic             wrap
);

    logic [WIDTH-1:0] out_q, out_d;
    logic             wrap_q, wrap_d;
    logic [WIDTH-1:0] inc_sum;
    logic             inc_carry;

    inc16 #(
        .WIDTH(WIDTH)
    ) u_inc16 (
        .a    (out_q),
        .sum  (inc_sum),
        .carry(inc_carry)
    );

    always_comb begin
        out_d  = out_q;
        wrap_d = 1'b0;
        if (clr) begin
            out_d = RESET_VAL;
        end else if (load) begin
            out_d = in;
        end else if (inc) begin
            out_d  = inc_sum;
            // Carry-out only flags the all-ones rollover; no saturation.
            wrap_d = inc_carry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= RESET_VAL;
            wrap_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign wrap = wrap_q;

endmodule

// File: tb/tb_program_counter.sv
// Scoreboard bench for program_counter: driver queues expectations, monitor checks each cycle.
module tb_program_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in = '0;
    logic        load = 1'b0;
    logic        inc = 1'b0;
    logic        clr = 1'b0;
    logic [15:0] out;
    logic        wrap;

    int n_checks = 0;
    int n_fails  = 0;

    typedef struct {
        logic [15:0] out;
        logic        wrap;
        string       name;
    } exp_t;

    exp_t sb[$];

    program_counter dut (
        .clk  (clk),
        .rst_n(rst_n),
        .in   (in),
        .load (load),
        .inc  (inc),
        .clr  (clr),
        .out  (out),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] exp_out, input logic exp_wrap);
        n_checks++;
        if (out !== exp_out || wrap !== exp_wrap) begin
            n_fails++;
            $display("FAIL %s: got out=%h wrap=%b, expected out=%h wrap=%b",
                     name, out, wrap, exp_out, exp_wrap);
        end
    endtask

    // Apply controls for one edge and queue the expected post-edge state.
    task automatic step(input string name, input logic c, input logic l, input logic i,
                        input logic [15:0] d, input logic [15:0] exp_out, input logic exp_wrap);
        exp_t e;
        clr  = c;
        load = l;
        inc  = i;
        in   = d;
        @(posedge clk);
        #1;
        e.out  = exp_out;
        e.wrap = exp_wrap;
        e.name = name;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check(e.name, e.out, e.wrap);
            end
        end
    end

    initial begin : driver
        #2;
        check("reset_initial", 16'h0000, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("load_42", 1'b0, 1'b1, 1'b0, 16'h0042, 16'h0042, 1'b0);

        // Async reset mid-cycle with load held.
        @(negedge clk);
        #2;
        load  = 1'b1;
        in    = 16'h1111;
        rst_n = 1'b0;
        #1;
        check("reset_async", 16'h0000, 1'b0);
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            check("reset_ignores_load", 16'h0000, 1'b0);
        end
        load  = 1'b0;
        in    = '0;
        rst_n = 1'b1;

        step("count_1", 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0);
        step("count_2", 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0002, 1'b0);
        step("count_3", 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0003, 1'b0);
        step("hold_a",  1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b0);
        step("hold_b",  1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b0);

        step("load_over_inc", 1'b0, 1'b1, 1'b1, 16'hABCD, 16'hABCD, 1'b0);
        step("inc_after_load", 1'b0, 1'b0, 1'b1, 16'h0000, 16'hABCE, 1'b0);

        step("load_ffff",  1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        step("wrap_pulse", 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b1);
        step("post_wrap",  1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0);

        step("load_ffff_2",   1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        step("reload_same",   1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        step("load_over_wrap", 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0);
        step("load_ffff_3",   1'b0, 1'b1, 1'b0, 16'hFFFF, 16'hFFFF, 1'b0);
        step("clr_at_ffff",   1'b1, 1'b0, 1'b1, 16'h0000, 16'h0000, 1'b0);

        step("load_1234", 1'b0, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0);
        step("clr_priority", 1'b1, 1'b1, 1'b1, 16'h5678, 16'h0000, 1'b0);

        step("load_1234_b", 1'b0, 1'b1, 1'b0, 16'h1234, 16'h1234, 1'b0);
        step("hold_in_5678", 1'b0, 1'b0, 1'b0, 16'h5678, 16'h1234, 1'b0);
        step("hold_in_9999", 1'b0, 1'b0, 1'b0, 16'h9999, 16'h1234, 1'b0);
        step("hold_in_0000", 1'b0, 1'b0, 1'b0, 16'h0000, 16'h1234, 1'b0);
        step("hold_in_5678b", 1'b0, 1'b0, 1'b0, 16'h5678, 16'h1234, 1'b0);

        // Reset mid-count loses the value.
        step("count_from_1234", 1'b0, 1'b0, 1'b1, 16'h0000, 16'h1235, 1'b0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("reset_mid_count", 16'h0000, 1'b0);
        inc = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        step("first_edge_after_reset", 1'b0, 1'b0, 1'b1, 16'h0000, 16'h0001, 1'b0);

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
